serial_adder_ctrl: RTL and testbench

//   Bit-serial adder controller: sequences one instance of the existing 1-bit

---
 rtl/serial_adder_ctrl.sv | 153 +++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder built around one full_adder.
// Operands are captured on an accepted start, one bit pair is added per clock
// (LSB first) with the carry held in a register, and the result word is
// presented with a one-cycle done pulse.
// Optional feature: define SERIAL_ADDER_SUB_EN to add a `sub` input that
// turns the operation into a - b (cout_out=1 means no borrow).

// 1-bit full adder used as the serial datapath element.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin_in,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout_out
);
    // Counter only has to reach WIDTH-1; keep at least one bit.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic              carry_q, carry_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  sum_out_q, sum_out_d;
    logic              cout_out_q, cout_out_d;

    logic              fa_sum;
    logic              fa_cout;

    // Operand conditioning at load time: subtraction is a + ~b + 1.
    logic [WIDTH-1:0]  b_load;
    logic              carry_load;
`ifdef SERIAL_ADDER_SUB_EN
    assign b_load     = sub ? ~b_in : b_in;
    assign carry_load = sub ? 1'b1  : cin_in;
`else
    assign b_load     = b_in;
    assign carry_load = cin_in;
`endif

    // The single adder always sees the current LSBs and the stored carry.
    full_adder u_fa (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            carry_q    <= 1'b0;
            cnt_q      <= '0;
            sum_out_q  <= '0;
            cout_out_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            acc_q      <= acc_d;
            carry_q    <= carry_d;
            cnt_q      <= cnt_d;
            sum_out_q  <= sum_out_d;
            cout_out_q <= cout_out_d;
        end
    end

    // Next-state and datapath sequencing: load in IDLE, shift in RUN,
    // publish the result on the final RUN edge.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        acc_d      = acc_q;
        carry_d    = carry_q;
        cnt_d      = cnt_q;
        sum_out_d  = sum_out_q;
        cout_out_d = cout_out_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a_in;
                    b_d     = b_load;
                    carry_d = carry_load;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                acc_d   = {fa_sum, acc_q[WIDTH-1:1]};
                carry_d = fa_cout;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    // Last bit: the freshly shifted word is the full result.
                    sum_out_d  = {fa_sum, acc_q[WIDTH-1:1]};
                    cout_out_d = fa_cout;
                    cnt_d      = '0;
                    state_d    = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign sum_out  = sum_out_q;
    assign cout_out = cout_out_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed and randomized operations
// on a WIDTH=8 instance, plus an exhaustive held-start sweep on a WIDTH=4
// instance. Expected results come from plain integer arithmetic.
// Define SERIAL_ADDER_SUB_EN to also exercise the subtract mode.
module tb_serial_adder_ctrl;
    localparam int W = 8;

    logic         clk;
    logic         rst_n;

    logic         start;
    logic [W-1:0] a_in, b_in;
    logic         cin_in;
    logic         sub;
    logic         busy, done, cout_out;
    logic [W-1:0] sum_out;

    logic         w4_start;
    logic [3:0]   w4_a, w4_b;
    logic         w4_cin;
    logic         w4_busy, w4_done, w4_cout;
    logic [3:0]   w4_sum;

    int checks   = 0;
    int failures = 0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a_in     (a_in),
        .b_in     (b_in),
        .cin_in   (cin_in),
`ifdef SERIAL_ADDER_SUB_EN
        .sub      (sub),
`endif
        .busy     (busy),
        .done     (done),
        .sum_out  (sum_out),
        .cout_out (cout_out)
    );

    serial_adder_ctrl #(.WIDTH(4)) dut4 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (w4_start),
        .a_in     (w4_a),
        .b_in     (w4_b),
        .cin_in   (w4_cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub      (1'b0),
`endif
        .busy     (w4_busy),
        .done     (w4_done),
        .sum_out  (w4_sum),
        .cout_out (w4_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One operation on the WIDTH=8 instance. Inputs change at negedges,
    // outputs are sampled at negedges. Sample 0 follows the accepting edge;
    // done must be seen at sample W and gone at sample W+1.
    task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic c, input logic s, input logic repulse);
        logic [8:0] exp;
        logic       early;
        if (s) exp = 9'({1'b0, a}) + 9'd256 - 9'({1'b0, b});
        else   exp = 9'({1'b0, a}) + 9'({1'b0, b}) + 9'(c);
        early = 1'b0;

        @(negedge clk);
        a_in = a; b_in = b; cin_in = c; sub = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a_in = 8'($urandom); b_in = 8'($urandom); cin_in = 1'($urandom);
        check({tag, "_busy_accept"}, 32'(busy), 32'd1);
        early = early | done;
        for (int k = 1; k < W; k++) begin
            @(negedge clk);
            early = early | done;
            if (repulse && k == 2) begin
                a_in = 8'h01; b_in = 8'h01; start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        check({tag, "_no_early_done"}, 32'(early), 32'd0);
        @(negedge clk);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_sum"}, 32'(sum_out), 32'(exp[7:0]));
        check({tag, "_cout"}, 32'(cout_out), 32'(exp[8]));
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'({done, busy}), 32'd0);
        check({tag, "_sum_held"}, 32'({cout_out, sum_out}), 32'(exp));
        $display("op %s a=%02h b=%02h cin=%0b sub=%0b -> sum=%02h cout=%0b exp=%03h",
                 tag, a, b, c, s, sum_out, cout_out, exp);
    endtask

    initial begin
        logic [4:0]  q4[$];
        logic [4:0]  e4;
        logic        seen;
        int          idx, got, cyc, last_done;

        rst_n = 1'b0; start = 1'b0; a_in = '0; b_in = '0; cin_in = 1'b0; sub = 1'b0;
        w4_start = 1'b0; w4_a = '0; w4_b = '0; w4_cin = 1'b0;
        #2;
        check("reset_outputs", 32'({busy, done, cout_out, sum_out}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset", 32'({busy, done}), 32'd0);

        // Directed arithmetic cases.
        do_op("t1", 8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0);
        do_op("t2a", 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
        do_op("t2b", 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
        do_op("zero", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

        // Start re-pulsed mid-operation must be ignored.
        do_op("t3", 8'h10, 8'h20, 1'b0, 1'b0, 1'b1);
        seen = 1'b0;
        for (int k = 0; k < 2 * W; k++) begin
            @(negedge clk);
            seen = seen | done | busy;
        end
        check("t3_no_second_op", 32'(seen), 32'd0);

        // Reset in the middle of RUN discards the operation.
        @(negedge clk);
        a_in = 8'hAA; b_in = 8'h55; cin_in = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t4_reset_clears", 32'({busy, done, cout_out, sum_out}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < W + 4; k++) begin
            @(negedge clk);
            seen = seen | done | busy;
        end
        check("t4_no_done_after_reset", 32'(seen), 32'd0);
        do_op("t4_after", 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
        do_op("t6a", 8'h10, 8'h01, 1'b1, 1'b1, 1'b0);
        do_op("t6b", 8'h01, 8'h02, 1'b0, 1'b1, 1'b0);
        do_op("sub0", 8'h33, 8'h44, 1'b1, 1'b0, 1'b0);
`endif

        // Randomized operations.
        for (int i = 0; i < 12; i++) begin
            logic s;
`ifdef SERIAL_ADDER_SUB_EN
            s = 1'($urandom);
`else
            s = 1'b0;
`endif
            do_op($sformatf("rnd%0d", i), 8'($urandom), 8'($urandom), 1'($urandom), s, 1'b0);
        end

        // WIDTH=4 exhaustive sweep with start held high: every result in order,
        // done pulses spaced WIDTH+2 = 6 cycles.
        idx = 0; got = 0; cyc = 0; last_done = -1;
        @(negedge clk);
        w4_a = 4'(idx); w4_b = 4'(idx >> 4); w4_cin = 1'(idx >> 8);
        q4.push_back(5'(w4_a) + 5'(w4_b) + 5'(w4_cin));
        idx = 1;
        w4_start = 1'b1;
        while (got < 512 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (w4_done) begin
                e4 = q4.pop_front();
                check($sformatf("t5_result%0d", got), 32'({w4_cout, w4_sum}), 32'(e4));
                if (last_done >= 0)
                    check($sformatf("t5_spacing%0d", got), 32'(cyc - last_done), 32'd6);
                if (got % 64 == 0)
                    $display("w4 op %0d result=%02h exp=%02h", got, {w4_cout, w4_sum}, e4);
                last_done = cyc;
                got++;
            end
            if (!w4_busy) begin
                if (idx < 512) begin
                    w4_a = 4'(idx); w4_b = 4'(idx >> 4); w4_cin = 1'(idx >> 8);
                    q4.push_back(5'(w4_a) + 5'(w4_b) + 5'(w4_cin));
                    idx++;
                end else begin
                    w4_start = 1'b0;
                end
            end
        end
        w4_start = 1'b0;
        check("t5_all_results", 32'(got), 32'd512);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
